// File: rtl/fg_pkg.sv
// Shared types, widths and helpers for the fan tach (FG) generator.
package fg_pkg;

  localparam int unsigned RPM_W        = 16;
  localparam int unsigned HALF_W       = 26;
  localparam int unsigned NUM_W        = 32;
  localparam int unsigned CLK_FREQ_DEF = 50_000_000;

  // 2 pulses/rev, 2 half-periods/pulse: half_cnt = 60*f/(4*rpm) = 15*f/rpm
  localparam int unsigned HALF_SCALE   = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RUN  = 2'd2
  } fg_state_e;

  // One generated speed setting: the RPM it represents and its half-period
  typedef struct packed {
    logic [RPM_W-1:0]  rpm;
    logic [HALF_W-1:0] half;
  } fg_set_t;

  // Clamp a non-zero request into [lo, hi]
  function automatic logic [RPM_W-1:0] clamp_rpm(input logic [RPM_W-1:0] rpm,
                                                 input logic [RPM_W-1:0] lo,
                                                 input logic [RPM_W-1:0] hi);
    logic [RPM_W-1:0] res;
    res = rpm;
    if (rpm < lo) res = lo;
    if (rpm > hi) res = hi;
    return res;
  endfunction

  // Dividend of the half-period division for a given clock frequency
  function automatic logic [NUM_W-1:0] half_numer(input int unsigned clk_freq);
    return NUM_W'(64'(HALF_SCALE) * 64'(clk_freq));
  endfunction

endpackage

// File: rtl/fg_div.sv
// Serial restoring divider, 32-bit dividend by 16-bit divisor, one quotient
// bit per cycle. Operands load on i_start; o_done pulses when the quotient
// is final, 32 cycles after the load. o_last_c flags the final step cycle.
module fg_div
  import fg_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             i_start,
  input  logic [NUM_W-1:0] i_num,
  input  logic [RPM_W-1:0] i_den,
  output logic [NUM_W-1:0] o_quot,
  output logic             o_done,
  output logic             o_last_c
);

  localparam int unsigned CNT_W = $clog2(NUM_W);

  logic [NUM_W-1:0] r_quot;
  logic [RPM_W-1:0] r_rem;
  logic [RPM_W-1:0] r_den;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [RPM_W:0]   w_shift;
  logic [RPM_W+1:0] w_diff;
  logic             w_fits;

  // Trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    w_shift = {r_rem, r_quot[NUM_W-1]};
    w_diff  = {1'b0, w_shift} - {2'b00, r_den};
    w_fits  = ~w_diff[RPM_W+1];
  end

  // Load operands on start, then retire one quotient bit per cycle
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_den  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_quot <= i_num;
        r_rem  <= '0;
        r_den  <= i_den;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem  <= w_fits ? w_diff[RPM_W-1:0] : w_shift[RPM_W-1:0];
        r_quot <= {r_quot[NUM_W-2:0], w_fits};
        r_cnt  <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(NUM_W-1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_quot   = r_quot;
  assign o_done   = r_done;
  assign o_last_c = r_busy && (r_cnt == CNT_W'(NUM_W-1));

endmodule

// File: rtl/fg_gen.sv
// Fan tach (FG) emulator: turns an RPM request into a 50% duty square wave
// at 2 pulses per revolution. Speed changes wait for the end of the current
// period so no partial pulse is emitted.
// Optional build macro FG_STALL_EN adds stall_in, which freezes the output
// and its phase counter to emulate a locked rotor.
module fg_gen
  import fg_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEF,
  parameter int unsigned RPM_MIN  = 30,
  parameter int unsigned RPM_MAX  = 20000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [RPM_W-1:0] rpm_in,
  input  logic             rpm_valid,
`ifdef FG_STALL_EN
  input  logic             stall_in,
`endif
  output logic             rpm_ready,
  output logic             fg_signal,
  output logic [RPM_W-1:0] rpm_active
);

  localparam logic [NUM_W-1:0]  NUMER    = half_numer(CLK_FREQ);
  localparam logic [RPM_W-1:0]  RPM_LO   = RPM_W'(RPM_MIN);
  localparam logic [RPM_W-1:0]  RPM_HI   = RPM_W'(RPM_MAX);
  localparam logic [HALF_W-1:0] HALF_ONE = HALF_W'(1);

  fg_state_e         r_state;
  logic              r_ready;
  logic              r_fg;
  logic              r_gen;
  logic              r_pend_valid;
  fg_set_t           r_pend;
  logic [RPM_W-1:0]  r_active;
  logic [RPM_W-1:0]  r_req_rpm;
  logic [HALF_W-1:0] r_half;
  logic [HALF_W-1:0] r_phase;

  logic              w_accept;
  logic              w_zero;
  logic              w_start;
  logic              w_stall;
  logic              w_div_done;
  logic              w_div_last;
  logic              w_at_end;
  logic              w_use_new;
  logic [RPM_W-1:0]  w_rpm_c;
  logic [NUM_W-1:0]  w_quot;
  fg_set_t           w_fresh;
  fg_set_t           w_next_set;

`ifdef FG_STALL_EN
  assign w_stall = stall_in;
`else
  assign w_stall = 1'b0;
`endif

  // Handshake decode, request clamping and selection of the next setting
  always_comb begin
    w_accept     = rpm_valid && r_ready;
    w_zero       = (rpm_in == '0);
    w_start      = w_accept && !w_zero;
    w_rpm_c      = clamp_rpm(rpm_in, RPM_LO, RPM_HI);
    w_fresh.rpm  = r_req_rpm;
    // Saturate rather than wrap if a build ever produces an oversized quotient
    w_fresh.half = (|w_quot[NUM_W-1:HALF_W]) ? '1 : w_quot[HALF_W-1:0];
    // A result finishing on the boundary cycle is used directly
    w_next_set   = w_div_done ? w_fresh : r_pend;
    w_use_new    = (w_div_done || r_pend_valid) && !w_accept;
    w_at_end     = (r_phase == r_half - HALF_ONE);
  end

  fg_div u_div (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .i_start  (w_start),
    .i_num    (NUMER),
    .i_den    (w_rpm_c),
    .o_quot   (w_quot),
    .o_done   (w_div_done),
    .o_last_c (w_div_last)
  );

  // Control FSM, pending-setting register and square-wave generator
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= IDLE;
      r_ready      <= 1'b1;
      r_fg         <= 1'b0;
      r_gen        <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend       <= '0;
      r_active     <= '0;
      r_req_rpm    <= '0;
      r_half       <= '0;
      r_phase      <= '0;
    end else begin
      case (r_state)
        IDLE, RUN: begin
          if (w_start) begin
            r_state   <= CALC;
            r_ready   <= 1'b0;
            r_req_rpm <= w_rpm_c;
          end else if (w_accept) begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          if (w_div_last) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase

      // Any accepted request supersedes a setting still waiting to apply
      if (w_accept) begin
        r_pend_valid <= 1'b0;
      end else if (w_div_done) begin
        r_pend_valid <= 1'b1;
        r_pend       <= w_fresh;
      end

      if (w_accept && w_zero) begin
        r_fg     <= 1'b0;
        r_gen    <= 1'b0;
        r_phase  <= '0;
        r_half   <= '0;
        r_active <= '0;
      end else if (!w_stall) begin
        if (!r_gen) begin
          // Stopped: start a fresh high phase once a setting is pending
          if (r_pend_valid && !w_accept) begin
            r_gen        <= 1'b1;
            r_fg         <= 1'b1;
            r_phase      <= '0;
            r_half       <= r_pend.half;
            r_active     <= r_pend.rpm;
            r_pend_valid <= 1'b0;
          end
        end else if (w_at_end) begin
          r_phase <= '0;
          r_fg    <= !r_fg;
          // End of the low phase is the period boundary
          if (!r_fg && w_use_new) begin
            r_half       <= w_next_set.half;
            r_active     <= w_next_set.rpm;
            r_pend_valid <= 1'b0;
          end
        end else begin
          r_phase <= r_phase + HALF_ONE;
        end
      end
    end
  end

  assign rpm_ready  = r_ready;
  assign fg_signal  = r_fg;
  assign rpm_active = r_active;

endmodule

// File: tb/tb_fg_gen.sv
// Bench for fg_gen, run at a reduced clock frequency so whole periods fit
// in a short simulation. Build with FG_STALL_EN to include the stall case.
module tb_fg_gen;
  import fg_pkg::*;

  localparam int unsigned TB_CLK = 20000;
  localparam int unsigned LIMIT  = 40000;

  logic             sys_clk   = 1'b0;
  logic             sys_rst   = 1'b1;
  logic [RPM_W-1:0] rpm_in    = '0;
  logic             rpm_valid = 1'b0;
  logic             rpm_ready;
  logic             fg_signal;
  logic [RPM_W-1:0] rpm_active;
`ifdef FG_STALL_EN
  logic             stall_in  = 1'b0;
`endif

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [RPM_W-1:0] rpm;
    logic [RPM_W-1:0] act;
    int unsigned      half;
  } vec_t;

  typedef struct {
    logic [RPM_W-1:0] act;
    int unsigned      hi;
    int unsigned      lo;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];

  fg_gen #(
    .CLK_FREQ (TB_CLK),
    .RPM_MIN  (30),
    .RPM_MAX  (20000)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .rpm_in     (rpm_in),
    .rpm_valid  (rpm_valid),
`ifdef FG_STALL_EN
    .stall_in   (stall_in),
`endif
    .rpm_ready  (rpm_ready),
    .fg_signal  (fg_signal),
    .rpm_active (rpm_active)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [RPM_W-1:0] rpm);
    rpm_in    = rpm;
    rpm_valid = 1'b1;
    tick();
    rpm_valid = 1'b0;
  endtask

  task automatic expect_period(input logic [RPM_W-1:0] act, input int unsigned hi,
                               input int unsigned lo);
    exp_t e;
    e.act = act;
    e.hi  = hi;
    e.lo  = lo;
    sb.push_back(e);
  endtask

  // Called on a rising-edge sample; returns on the next rising-edge sample
  task automatic check_period(input string name);
    exp_t             e;
    int unsigned      hi;
    int unsigned      lo;
    logic [RPM_W-1:0] act;
    hi = 0;
    lo = 0;
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: no expected period queued", name);
      return;
    end
    e   = sb.pop_front();
    act = rpm_active;
    while (fg_signal === 1'b1 && hi < LIMIT) begin hi++; tick(); end
    while (fg_signal === 1'b0 && lo < LIMIT) begin lo++; tick(); end
    check({name, " rpm_active"}, act, e.act);
    check({name, " high cycles"}, hi, e.hi);
    check({name, " low cycles"}, lo, e.lo);
  endtask

  task automatic count_high(input string name, input int n);
    int hits;
    hits = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (fg_signal !== 1'b0) hits++;
    end
    check({name, " fg quiet"}, hits, 0);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " fg_signal"}, fg_signal, 0);
    check({name, " rpm_ready"}, rpm_ready, 1);
    check({name, " rpm_active"}, rpm_active, 0);
  endtask

  // Request from a stopped generator and verify the start-up timeline
  task automatic run_from_idle(input string name, input logic [RPM_W-1:0] rpm,
                               input logic [RPM_W-1:0] act, input int unsigned half);
    expect_period(act, half, half);
    send(rpm);
    check({name, " ready low first"}, rpm_ready, 0);
    repeat (31) tick();
    check({name, " ready low last"}, rpm_ready, 0);
    tick();
    check({name, " ready back"}, rpm_ready, 1);
    tick();
    check({name, " fg before rise"}, fg_signal, 0);
    check({name, " active before rise"}, rpm_active, 0);
    tick();
    check({name, " fg rise"}, fg_signal, 1);
    check_period(name);
  endtask

  initial begin
    vecs[0] = '{16'd2000,  16'd2000,  150};
    vecs[1] = '{16'd10,    16'd30,    10000};
    vecs[2] = '{16'd60000, 16'd20000, 15};
    vecs[3] = '{16'd4000,  16'd4000,  75};
    vecs[4] = '{16'd7000,  16'd7000,  42};
    vecs[5] = '{16'd2001,  16'd2001,  149};
    vecs[6] = '{16'd20001, 16'd20000, 15};

    repeat (3) tick();
    for (int i = 0; i < 7; i++) begin
      sys_rst = 1'b1;
      tick();
      check_reset_vals($sformatf("vec%0d reset", i));
      sys_rst = 1'b0;
      run_from_idle($sformatf("vec%0d", i), vecs[i].rpm, vecs[i].act, vecs[i].half);
    end

    // Speed change mid high-phase waits for the period boundary
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    run_from_idle("base", 16'd2000, 16'd2000, 150);
    expect_period(16'd2000, 150, 150);
    expect_period(16'd4000, 75, 75);
    fork
      begin check_period("midreq p0"); check_period("midreq p1"); end
      begin repeat (20) tick(); send(16'd4000); end
    join

    // Divider finishing on the boundary cycle applies at that boundary
    expect_period(16'd4000, 75, 75);
    expect_period(16'd2000, 150, 150);
    fork
      begin check_period("edge p0"); check_period("edge p1"); end
      begin repeat (116) tick(); send(16'd2000); end
    join

    // A second request replaces the one still pending
    expect_period(16'd2000, 150, 150);
    expect_period(16'd20000, 15, 15);
    fork
      begin check_period("replace p0"); check_period("replace p1"); end
      begin repeat (5) tick(); send(16'd4000); repeat (40) tick(); send(16'd20000); end
    join

    // Zero request stops immediately
    repeat (5) tick();
    send(16'd0);
    check("stop fg_signal", fg_signal, 0);
    check("stop rpm_active", rpm_active, 0);
    check("stop rpm_ready", rpm_ready, 1);
    count_high("stopped", 200);

    // Strobe during CALC from idle is ignored and not queued
    expect_period(16'd2000, 150, 150);
    expect_period(16'd2000, 150, 150);
    send(16'd2000);
    repeat (5) tick();
    send(16'd1000);
    repeat (26) tick();
    check("ign ready back", rpm_ready, 1);
    tick();
    check("ign fg before rise", fg_signal, 0);
    tick();
    check("ign fg rise", fg_signal, 1);
    check_period("ign p0");
    check_period("ign p1");

    // Strobe during CALC while running is ignored
    expect_period(16'd2000, 150, 150);
    expect_period(16'd4000, 75, 75);
    expect_period(16'd4000, 75, 75);
    fork
      begin check_period("ignrun p0"); check_period("ignrun p1"); check_period("ignrun p2"); end
      begin repeat (3) tick(); send(16'd4000); repeat (3) tick(); send(16'd60000); end
    join

    // Reset in the middle of a division
    send(16'd2000);
    repeat (10) tick();
    sys_rst = 1'b1;
    tick();
    check_reset_vals("rst calc");
    sys_rst = 1'b0;
    count_high("rst calc", 60);
    run_from_idle("after rst calc", 16'd2000, 16'd2000, 150);

    // Reset in the middle of a high phase
    repeat (40) tick();
    sys_rst = 1'b1;
    tick();
    check_reset_vals("rst run");
    sys_rst = 1'b0;
    count_high("rst run", 400);
    run_from_idle("after rst run", 16'd2000, 16'd2000, 150);

`ifdef FG_STALL_EN
    // Stall stretches the high phase, later periods are unaffected
    expect_period(16'd2000, 1150, 150);
    expect_period(16'd2000, 150, 150);
    fork
      begin check_period("stall p0"); check_period("stall p1"); end
      begin repeat (10) tick(); stall_in = 1'b1; repeat (1000) tick(); stall_in = 1'b0; end
    join
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fg_gen.md
FG_GEN -- requirements
Module: fg_gen

Interface
REQ-001 Parameter CLK_FREQ, default 50000000: sys_clk frequency in Hz.
REQ-002 Parameter RPM_MIN, default 30: lowest non-zero generated speed; smaller non-zero requests are clamped up to it.
REQ-003 Parameter RPM_MAX, default 20000: highest generated speed; larger requests are clamped down to it.
REQ-004 sys_clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 sys_rst  in  1  reset, synchronous, active-high.
REQ-006 rpm_in  in  16  requested fan speed in RPM, unsigned.
REQ-007 rpm_valid  in  1  request strobe; a transfer occurs on a cycle with rpm_valid and rpm_ready both high.
REQ-008 rpm_ready  out  1  high when a new request can be accepted.
REQ-009 fg_signal  out  1  emulated fan tach output, 50% duty, 2 pulses per revolution.
REQ-010 rpm_active  out  16  clamped RPM currently being generated; 0 when stopped.

Function
REQ-011 Half-period in clocks SHALL be half_cnt = (15*CLK_FREQ) / rpm_c, truncated, where rpm_c is the clamped request; 26-bit half_cnt, 32-bit numerator.
REQ-012 With the defaults, rpm_c=2000 SHALL give half_cnt=375000 (period 750000), and rpm_c=30 SHALL give half_cnt=25000000.
REQ-013 States: IDLE (fg_signal low, no period), CALC (division in progress), RUN (generating). rpm_ready SHALL be low exactly while in CALC.
REQ-014 Accepting a non-zero request SHALL enter CALC; the divider SHALL take exactly 32 cycles; its result is then loaded into a pending register.
REQ-015 From IDLE, fg_signal SHALL first rise exactly 34 cycles after the accepting edge, and rpm_active SHALL update on that same edge.
REQ-016 In RUN, fg_signal SHALL be high for half_cnt cycles, then low for half_cnt cycles, and then repeat. The period boundary is the last low cycle.
REQ-017 A pending value computed while RUN SHALL take effect only at the next period boundary, so no partial pulse is produced. rpm_active SHALL change on that same edge.
REQ-018 While a pending value awaits its boundary, the FSM SHALL be in RUN with rpm_ready high. A further accepted request SHALL restart CALC and replace the pending value.
REQ-019 If the divider completes on the boundary cycle, the new half_cnt SHALL apply at that boundary.
REQ-020 Accepting rpm_in=0 SHALL, on the next edge, drive fg_signal low, clear the phase counter, clear rpm_active, discard any pending value, and enter IDLE; no division is performed.
REQ-021 rpm_valid while rpm_ready is low SHALL be ignored; no request is queued.

Reset
REQ-022 On sys_rst high at a clock edge: fg_signal=0, rpm_ready=1, rpm_active=0, state IDLE, phase counter=0, pending cleared.
REQ-023 Reset during CALC or RUN SHALL abort the division and the current pulse immediately; the first post-reset request SHALL behave as from IDLE.

Configuration
REQ-024 Macro FG_STALL_EN defined: an extra input port stall_in (1 bit) SHALL exist. While stall_in is high, fg_signal and the phase counter hold their values, emulating a locked rotor. rpm_active and the request handshake remain unaffected.
REQ-025 FG_STALL_EN undefined: the stall_in port and its logic SHALL be absent, and the behaviour is as REQ-011..REQ-023.

Structure
REQ-026 Shared package fg_pkg SHALL hold the FSM state enum (IDLE, CALC, RUN), the width constants RPM_W=16, HALF_W=26 and NUM_W=32, and the default CLK_FREQ.
REQ-027 Sub-module fg_div SHALL implement a serial restoring divider, 32-bit by 16-bit, one quotient bit per cycle, with start/done pulses and a synchronous active-high reset on sys_clk.

Verification
REQ-028 Reset, then rpm_in=2000 accepted at cycle T -> rpm_ready low T+1..T+32; fg_signal rises at T+34; high 375000 cycles, low 375000; rpm_active=2000.
REQ-029 rpm_in=10 -> clamped, half_cnt=25000000, rpm_active=30; rpm_in=60000 -> half_cnt=37500, rpm_active=20000.
REQ-030 Running at 2000, request 4000 mid high-phase -> current 750000-cycle period completes intact, then period 375000; no glitch.
REQ-031 Running, request 0 -> next cycle fg_signal=0, rpm_active=0, state IDLE; rpm_valid pulsed during CALC -> ignored, rpm_active unchanged.
REQ-032 sys_rst asserted mid-CALC and mid high-phase -> outputs at reset values next edge; subsequent request at 2000 reproduces REQ-028 timing.
REQ-033 FG_STALL_EN defined: stall_in high for 1000 cycles during the high phase -> that high phase lasts 376000 cycles; period unaffected afterward.
